// File: rtl/ultrasonic_echo_emulator_pkg.sv
// Shared types and default timing for the ultrasonic echo emulator.
// Default constants model a real HC-SR04 burst and echo timing.
// The state encoding is binary and is shared with any detector-side tooling.
package ultrasonic_pkg;

  localparam int DIST_W            = 12;
  localparam int CLKS_PER_UNIT_DEF = 442;
  localparam int MIN_TRIG_DEF      = 200;
  localparam int RESP_DELAY_DEF    = 2700;
  localparam int HOLDOFF_DEF       = 1000;
  localparam int MAX_UNITS_DEF     = (1 << DIST_W) - 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_TRIG_HI = 3'd1,
    ST_DELAY   = 3'd2,
    ST_ECHO    = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ultrasonic_echo_emulator_if.sv
// Sensor-side signal bundle between the range-detect controller and the emulator.
// master = controller (drives trig/distance), slave = emulator (drives echo/status).
// Purely combinational wiring, no state.
interface ultrasonic_echo_emulator_if;
  import ultrasonic_pkg::*;

  logic              trig;
  logic [DIST_W-1:0] distance_set;
  logic              echo;
  logic              busy;
  logic              trig_reject;
  logic [15:0]       meas_count;

  modport master (
    output trig, distance_set,
    input  echo, busy, trig_reject, meas_count
  );

  modport slave (
    input  trig, distance_set,
    output echo, busy, trig_reject, meas_count
  );

endinterface

// File: rtl/ultrasonic_echo_emulator_sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous level, with rise/fall pulses.
// Latency: 2 cycles to o_sync; edge pulses are combinational on the synced level.
// No backpressure; pulses last one cycle.
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // Metastability chain plus one delayed copy for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;
  assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/ultrasonic_echo_emulator.sv
// HC-SR04-style responder: qualifies trigger width, waits the burst delay, returns echo of dist*CLKS_PER_UNIT cycles.
// Latency: echo rises RESP_DELAY+3 cycles after trig falls (2 sync + 1 edge-to-state register).
// No backpressure; triggers arriving while busy are dropped and flagged on trig_reject.
module ultrasonic_echo_emulator
  import ultrasonic_pkg::*;
#(
  parameter int CLKS_PER_UNIT = CLKS_PER_UNIT_DEF,
  parameter int MIN_TRIG      = MIN_TRIG_DEF,
  parameter int RESP_DELAY    = RESP_DELAY_DEF,
  parameter int HOLDOFF       = HOLDOFF_DEF,
  parameter int MAX_UNITS     = MAX_UNITS_DEF
) (
  input logic                       clk,
  input logic                       rst_n,
  ultrasonic_echo_emulator_if.slave bus
);

  localparam int HI_W    = cnt_width(MIN_TRIG);
  localparam int TMR_MAX = (RESP_DELAY > HOLDOFF) ? RESP_DELAY : HOLDOFF;
  localparam int TMR_W   = cnt_width(TMR_MAX);
  localparam int SUB_W   = cnt_width(CLKS_PER_UNIT);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [HI_W-1:0]   r_hi_cnt;
  logic [TMR_W-1:0]  r_tmr;
  logic [SUB_W-1:0]  r_sub_cnt;
  logic [DIST_W-1:0] r_unit_cnt;
  logic [DIST_W-1:0] r_dist;
  logic [DIST_W-1:0] w_dist_clamp;
  logic [15:0]       r_meas_count;
  logic              r_echo;
  logic              r_trig_reject;
  logic              w_trig_s;
  logic              w_rise;
  logic              w_fall;
  logic              w_accept;
  logic              w_reject;
  logic              w_sub_last;
  logic              w_unit_last;
  logic              w_dly_done;
  logic              w_ho_done;

  sync_edge_detect u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (bus.trig),
    .o_sync  (w_trig_s),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_dist_clamp = (bus.distance_set > DIST_W'(MAX_UNITS)) ? DIST_W'(MAX_UNITS)
                                                                 : bus.distance_set;
  assign w_sub_last   = (r_sub_cnt == SUB_W'(CLKS_PER_UNIT - 1));
  assign w_unit_last  = (r_unit_cnt == r_dist - DIST_W'(1));
  assign w_dly_done   = (r_tmr == TMR_W'(RESP_DELAY - 1));
  assign w_ho_done    = (r_tmr == TMR_W'(HOLDOFF - 1));

  // Next-state decode; any new trigger edge outside IDLE/TRIG_HI is dropped and flagged.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_reject    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rise) w_state_nxt = ST_TRIG_HI;
      end
      ST_TRIG_HI: begin
        if (w_fall) begin
          if (r_hi_cnt >= HI_W'(MIN_TRIG)) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_DELAY;
          end else begin
            w_reject    = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_DELAY: begin
        w_reject = w_rise;
        if (w_dly_done) w_state_nxt = (r_dist == '0) ? ST_HOLDOFF : ST_ECHO;
      end
      ST_ECHO: begin
        w_reject = w_rise;
        if (w_sub_last && w_unit_last) w_state_nxt = ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        w_reject = w_rise;
        if (w_ho_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State register, registered outputs and measurement bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_echo        <= 1'b0;
      r_trig_reject <= 1'b0;
      r_meas_count  <= '0;
      r_dist        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_echo        <= (w_state_nxt == ST_ECHO);
      r_trig_reject <= w_reject;
      if (w_accept) begin
        r_meas_count <= r_meas_count + 16'd1;
        r_dist       <= w_dist_clamp;
      end
    end
  end

  // Trigger-width counter; saturates so an indefinitely held trigger never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_rise) r_hi_cnt <= HI_W'(1);
    end else if (r_state == ST_TRIG_HI) begin
      if (w_trig_s && (r_hi_cnt < HI_W'(MIN_TRIG))) r_hi_cnt <= r_hi_cnt + HI_W'(1);
    end
  end

  // Shared timer for burst delay and holdoff; restarts on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr <= '0;
    end else if (w_state_nxt != r_state) begin
      r_tmr <= '0;
    end else if ((r_state == ST_DELAY) || (r_state == ST_HOLDOFF)) begin
      r_tmr <= r_tmr + TMR_W'(1);
    end
  end

  // Echo width as nested unit/sub-unit counters, avoiding a dist*CLKS_PER_UNIT multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub_cnt  <= '0;
      r_unit_cnt <= '0;
    end else if (r_state != ST_ECHO) begin
      r_sub_cnt  <= '0;
      r_unit_cnt <= '0;
    end else if (w_sub_last) begin
      r_sub_cnt  <= '0;
      r_unit_cnt <= r_unit_cnt + DIST_W'(1);
    end else begin
      r_sub_cnt  <= r_sub_cnt + SUB_W'(1);
    end
  end

  assign bus.echo        = r_echo;
  assign bus.busy        = (r_state != ST_IDLE);
  assign bus.trig_reject = r_trig_reject;
  assign bus.meas_count  = r_meas_count;

endmodule

// File: tb/tb_ultrasonic_echo_emulator.sv
// Scoreboard bench: each trigger pulse is resolved by a timeline model into expected
// echo windows, reject pulses and busy-fall times; a negedge monitor pops and compares.
module tb_ultrasonic_echo_emulator;

  localparam int CPU        = 4;
  localparam int MIN_TRIG   = 8;
  localparam int RESP_DELAY = 10;
  localparam int HOLDOFF    = 5;
  localparam int MAX_UNITS  = 6;

  typedef struct {
    int rise;
    int width;
  } echo_exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   errors;

  echo_exp_t echo_q[$];
  int        rej_q[$];
  int        idle_q[$];
  int        busy_end;
  logic [15:0] model_meas;

  ultrasonic_echo_emulator_if bus ();

  ultrasonic_echo_emulator #(
    .CLKS_PER_UNIT (CPU),
    .MIN_TRIG      (MIN_TRIG),
    .RESP_DELAY    (RESP_DELAY),
    .HOLDOFF       (HOLDOFF),
    .MAX_UNITS     (MAX_UNITS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit (actual cycle %0d, required finish earlier)", cyc);
    $fatal(1);
  end

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: actual %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Issue one trigger pulse of n high cycles and predict its outcome from the rules.
  task automatic pulse(input int n, input int d);
    int k;
    int a;
    int dc;
    @(posedge clk);
    #1;
    k = cyc;
    bus.distance_set = 12'(d);
    bus.trig = 1'b1;
    // Rise is acted on at edge k+3; the FSM must already be idle during cycle k+2.
    if (busy_end > k + 2) begin
      rej_q.push_back(k + 3);
    end else if (n < MIN_TRIG) begin
      rej_q.push_back(k + n + 3);
      idle_q.push_back(k + n + 3);
      busy_end = k + n + 3;
    end else begin
      a  = k + n + 3;
      dc = (d > MAX_UNITS) ? MAX_UNITS : d;
      model_meas = model_meas + 16'd1;
      if (dc != 0) echo_q.push_back('{rise: a + RESP_DELAY, width: dc * CPU});
      busy_end = a + RESP_DELAY + dc * CPU + HOLDOFF;
      idle_q.push_back(busy_end);
    end
    repeat (n) @(posedge clk);
    #1 bus.trig = 1'b0;
    repeat (3) @(posedge clk);
    #1 chk(bus.meas_count == model_meas, "meas_count", bus.meas_count, model_meas);
  endtask

  task automatic wait_idle();
    while (cyc <= busy_end + 1) @(posedge clk);
  endtask

  // Monitor: compare every echo edge, reject pulse and busy fall against the queues.
  initial begin
    bit in_echo;
    bit prev_echo;
    bit prev_busy;
    int rise_cyc;
    int cur_width;
    int e_cyc;
    echo_exp_t e;
    in_echo = 0; prev_echo = 0; prev_busy = 0; rise_cyc = 0; cur_width = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_echo = 0; prev_echo = 0; prev_busy = 0;
      end else begin
        if (bus.echo && !prev_echo) begin
          if (echo_q.size() == 0) begin
            chk(1'b0, "echo_unexpected_rise", cyc, -1);
          end else begin
            e = echo_q.pop_front();
            chk(cyc == e.rise, "echo_rise_cycle", cyc, e.rise);
            rise_cyc = cyc; cur_width = e.width; in_echo = 1;
          end
        end
        if (!bus.echo && prev_echo && in_echo) begin
          chk(cyc - rise_cyc == cur_width, "echo_width", cyc - rise_cyc, cur_width);
          in_echo = 0;
        end
        if (bus.trig_reject) begin
          if (rej_q.size() == 0) chk(1'b0, "reject_unexpected", cyc, -1);
          else begin
            e_cyc = rej_q.pop_front();
            chk(cyc == e_cyc, "reject_cycle", cyc, e_cyc);
          end
        end
        if (!bus.busy && prev_busy) begin
          if (idle_q.size() == 0) chk(1'b0, "busy_unexpected_fall", cyc, -1);
          else begin
            e_cyc = idle_q.pop_front();
            chk(cyc == e_cyc, "busy_fall_cycle", cyc, e_cyc);
          end
        end
        prev_echo = bus.echo;
        prev_busy = bus.busy;
      end
    end
  end

  initial begin
    int t;
    checks = 0; errors = 0; busy_end = 0; model_meas = 16'd0;
    rst_n = 1'b0;
    bus.trig = 1'b0;
    bus.distance_set = 12'd0;
    repeat (3) @(posedge clk);
    #1;
    chk(bus.echo == 1'b0, "reset_echo", bus.echo, 0);
    chk(bus.busy == 1'b0, "reset_busy", bus.busy, 0);
    chk(bus.trig_reject == 1'b0, "reset_reject", bus.trig_reject, 0);
    chk(bus.meas_count == 16'd0, "reset_meas", bus.meas_count, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Nominal, short, width boundary, zero distance, clamp, saturation.
    pulse(12, 3);   wait_idle();
    pulse(5, 3);    wait_idle();
    pulse(7, 2);    wait_idle();
    pulse(8, 2);    wait_idle();
    pulse(12, 0);   wait_idle();
    pulse(12, 100); wait_idle();
    pulse(35, 1);   wait_idle();

    // Retrigger during echo.
    pulse(12, 5);
    t = 0;
    while (!bus.echo && t < 100) begin @(posedge clk); #1; t++; end
    chk(bus.echo == 1'b1, "echo_before_retrigger", bus.echo, 1);
    pulse(3, 0);
    wait_idle();

    // Distance change after latch point.
    pulse(12, 2);
    bus.distance_set = 12'd6;
    wait_idle();

    // Reset mid-echo.
    pulse(12, 5);
    t = 0;
    while (!bus.echo && t < 100) begin @(posedge clk); #1; t++; end
    chk(bus.echo == 1'b1, "echo_before_reset", bus.echo, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk(bus.echo == 1'b0, "async_reset_echo", bus.echo, 0);
    chk(bus.busy == 1'b0, "async_reset_busy", bus.busy, 0);
    chk(bus.meas_count == 16'd0, "async_reset_meas", bus.meas_count, 0);
    echo_q.delete(); rej_q.delete(); idle_q.delete();
    model_meas = 16'd0;
    busy_end = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    pulse(12, 3);   wait_idle();

    // Randomized sequence, including triggers that land while busy.
    for (int i = 0; i < 40; i++) begin
      pulse(int'($urandom_range(3, 14)), int'($urandom_range(0, 15)));
      repeat ($urandom_range(0, 25)) @(posedge clk);
    end
    wait_idle();

    // Counter wrap.
    force dut.r_meas_count = 16'hFFFF;
    @(posedge clk);
    #1 release dut.r_meas_count;
    model_meas = 16'hFFFF;
    pulse(12, 1);
    wait_idle();

    repeat (5) @(posedge clk);
    #1;
    chk(echo_q.size() == 0, "echo_queue_drained", echo_q.size(), 0);
    chk(rej_q.size() == 0, "reject_queue_drained", rej_q.size(), 0);
    chk(idle_q.size() == 0, "busy_queue_drained", idle_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
